// File: rtl/servo_sequencer_if.sv
// servo_sequencer_if: configuration, control and status bundle between host logic and the sequencer.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; host-side signals are sampled every cycle by the sequencer.
interface servo_sequencer_if #(
    parameter int NUM_SERVOS = 4,
    parameter int DEPTH      = 16,
    parameter int DWELL_W    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                  cfg_we;
    logic [AW-1:0]         cfg_addr;
    logic [NUM_SERVOS-1:0] cfg_pos;
    logic [DWELL_W-1:0]    cfg_dwell;
    logic                  cfg_last;
    logic                  start;
    logic                  stop;
    logic                  busy;
    logic                  done;
    logic [AW-1:0]         step_idx;
    logic [NUM_SERVOS-1:0] pos_out;
    logic                  main_program;
    logic                  frame_tick;

    // Host / config side.
    modport master (
        output cfg_we, cfg_addr, cfg_pos, cfg_dwell, cfg_last, start, stop,
        input  busy, done, step_idx, pos_out, main_program, frame_tick
    );

    // Sequencer side.
    modport slave (
        input  cfg_we, cfg_addr, cfg_pos, cfg_dwell, cfg_last, start, stop,
        output busy, done, step_idx, pos_out, main_program, frame_tick
    );
endinterface

// File: rtl/servo_sequencer.sv
// servo_sequencer: steps a table of servo position masks, each held for whole PWM frames.
// Latency: start sampled at edge E -> busy/main_program/pos_out valid from E+1; all outputs registered.
// Backpressure: none; table writes accepted any cycle, start ignored while running, stop aborts next edge.
// Optional macro SERVO_SEQ_LOOP_EN: after the last step, restart at entry 0 instead of finishing.
module servo_sequencer #(
    parameter int NUM_SERVOS = 4,
    parameter int DEPTH      = 16,
    parameter int FRAME_CLKS = 1000000,
    parameter int DWELL_W    = 8
) (
    input logic             mclk,
    input logic             reset,
    servo_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CLKS - 1);
    // Count value one cycle before the frame's final cycle, used to register frame_tick.
    localparam logic [FW-1:0] FRAME_PRE  = FW'((FRAME_CLKS > 1) ? FRAME_CLKS - 2 : 0);
    // With a one-cycle frame every running cycle is a frame end.
    localparam logic TICK_AT_ZERO = (FRAME_CLKS == 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Step table.
    logic [NUM_SERVOS-1:0] tbl_pos   [DEPTH];
    logic [DWELL_W-1:0]    tbl_dwell [DEPTH];
    logic                  tbl_last  [DEPTH];

    // Sequencer state and registered outputs.
    state_t                state;
    logic                  cur_last;
    logic [DWELL_W-1:0]    dwell_cnt;
    logic [FW-1:0]         frame_cnt;
    logic                  busy;
    logic                  done;
    logic [AW-1:0]         step_idx;
    logic [NUM_SERVOS-1:0] pos_out;
    logic                  main_program;
    logic                  frame_tick;

    // Next-entry selection and the fields it would load this cycle.
    logic                  frame_end;
    logic                  seq_end;
    logic [AW-1:0]         ld_idx;
    logic [NUM_SERVOS-1:0] ld_pos;
    logic [DWELL_W-1:0]    ld_dwell;
    logic                  ld_last;

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.step_idx     = step_idx;
    assign bus.pos_out      = pos_out;
    assign bus.main_program = main_program;
    assign bus.frame_tick   = frame_tick;

    // Table writes; reset clears every entry to {0, 0, 0}.
    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_pos[i]   <= '0;
                tbl_dwell[i] <= '0;
                tbl_last[i]  <= 1'b0;
            end
        end else if (bus.cfg_we) begin
            tbl_pos[bus.cfg_addr]   <= bus.cfg_pos;
            tbl_dwell[bus.cfg_addr] <= bus.cfg_dwell;
            tbl_last[bus.cfg_addr]  <= bus.cfg_last;
        end
    end

    // Pick the entry a load would use; reads the pre-write table contents.
    always_comb begin
        frame_end = (frame_cnt == FRAME_LAST);
        seq_end   = cur_last || (step_idx == IDX_LAST);
        ld_idx    = '0;
        if (state == RUN && !seq_end) begin
            ld_idx = step_idx + 1'b1;
        end
        ld_pos   = tbl_pos[ld_idx];
        ld_last  = tbl_last[ld_idx];
        ld_dwell = (tbl_dwell[ld_idx] == '0) ? DWELL_W'(1) : tbl_dwell[ld_idx];
    end

    // IDLE/RUN control with frame counting and registered outputs.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state        <= IDLE;
            cur_last     <= 1'b0;
            dwell_cnt    <= '0;
            frame_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            step_idx     <= '0;
            pos_out      <= '0;
            main_program <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        main_program <= 1'b1;
                        pos_out      <= ld_pos;
                        step_idx     <= ld_idx;
                        dwell_cnt    <= ld_dwell;
                        cur_last     <= ld_last;
                        frame_cnt    <= '0;
                        frame_tick   <= TICK_AT_ZERO;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        main_program <= 1'b0;
                        frame_tick   <= 1'b0;
                    end else if (!frame_end) begin
                        frame_cnt  <= frame_cnt + 1'b1;
                        frame_tick <= (frame_cnt == FRAME_PRE);
                    end else if (dwell_cnt > DWELL_W'(1)) begin
                        dwell_cnt  <= dwell_cnt - 1'b1;
                        frame_cnt  <= '0;
                        frame_tick <= TICK_AT_ZERO;
                    end else if (seq_end) begin
`ifdef SERVO_SEQ_LOOP_EN
                        pos_out    <= ld_pos;
                        step_idx   <= ld_idx;
                        dwell_cnt  <= ld_dwell;
                        cur_last   <= ld_last;
                        frame_cnt  <= '0;
                        frame_tick <= TICK_AT_ZERO;
`else
                        state        <= IDLE;
                        busy         <= 1'b0;
                        main_program <= 1'b0;
                        frame_tick   <= 1'b0;
                        frame_cnt    <= '0;
                        done         <= 1'b1;
`endif
                    end else begin
                        pos_out    <= ld_pos;
                        step_idx   <= ld_idx;
                        dwell_cnt  <= ld_dwell;
                        cur_last   <= ld_last;
                        frame_cnt  <= '0;
                        frame_tick <= TICK_AT_ZERO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
